// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: payload + control with valid/ready, flush and optional 2-entry skid.
// Latency 1 cycle; SKID=1 gives a registered o_ready at full throughput, SKID=0 gives a combinational o_ready.
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
    logic [CTRL_WIDTH-1:0] main_ctl_q, main_ctl_d;
    logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic [CTRL_WIDTH-1:0] skid_ctl_q, skid_ctl_d;
    logic                  rdy_q, rdy_d;
    logic                  in_xfer, out_xfer;

    assign o_valid  = (state_q != ST_EMPTY);
    assign o_ready  = SKID ? rdy_q : (!o_valid || i_ready);
    assign o_data   = main_dat_q;
    assign o_ctrl   = o_valid ? main_ctl_q : '0;
    assign o_count  = (state_q == ST_FULL) ? 2'd2 : ((state_q == ST_BUSY) ? 2'd1 : 2'd0);
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_comb begin
        state_d    = state_q;
        main_dat_d = main_dat_q;
        main_ctl_d = main_ctl_q;
        skid_dat_d = skid_dat_q;
        skid_ctl_d = skid_ctl_q;
        if (i_flush) begin
            // Contents are dropped by invalidating them; data registers keep their last value.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_dat_d = i_data;
                        main_ctl_d = i_ctrl;
                        state_d    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && (out_xfer || !SKID)) begin
                        main_dat_d = i_data;
                        main_ctl_d = i_ctrl;
                    end else if (in_xfer) begin
                        skid_dat_d = i_data;
                        skid_ctl_d = i_ctrl;
                        state_d    = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_dat_d = skid_dat_q;
                        main_ctl_d = skid_ctl_q;
                        state_d    = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_dat_q <= '0;
            main_ctl_q <= '0;
            skid_dat_q <= '0;
            skid_ctl_q <= '0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_dat_q <= main_dat_d;
            main_ctl_q <= main_ctl_d;
            skid_dat_q <= skid_dat_d;
            skid_ctl_q <= skid_ctl_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 1 uses the skid buffer, instance 0 is single-entry.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld[2], flush[2], rdy[2], ovld[2], ordy[2];
    logic [63:0] dat[2], odat[2];
    logic [7:0]  ctl[2], octl[2];
    logic [1:0]  cnt[2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]), .i_data(dat[1]),
        .i_ctrl(ctl[1]), .i_flush(flush[1]), .o_valid(ovld[1]), .i_ready(rdy[1]),
        .o_data(odat[1]), .o_ctrl(octl[1]), .o_count(cnt[1])
    );

    pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]), .i_data(dat[0]),
        .i_ctrl(ctl[0]), .i_flush(flush[0]), .o_valid(ovld[0]), .i_ready(rdy[0]),
        .o_data(odat[0]), .o_ctrl(octl[0]), .o_count(cnt[0])
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  c;
        logic        f;
        logic        r;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ec;
        logic [1:0]  en;
        logic        er;
    } vec_t;

    vec_t tbl[13];

    // Reference model: an in-order list of accepted entries, capacity 2 (skid) or 1.
    logic [71:0] mem[2][0:15];
    int unsigned wr[2], rd[2];
    int unsigned n;
    logic        acc[2], exp_rdy;
    int          rp;
    string       tag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_out(input int k, input string t, input logic ev, input logic [63:0] ed,
                             input logic [7:0] ec, input logic [1:0] en, input logic er,
                             input bit cmp_dat);
        chk({t, ".o_valid"}, {63'd0, ovld[k]}, {63'd0, ev});
        chk({t, ".o_ready"}, {63'd0, ordy[k]}, {63'd0, er});
        chk({t, ".o_count"}, {62'd0, cnt[k]}, {62'd0, en});
        chk({t, ".o_ctrl"}, {56'd0, octl[k]}, {56'd0, ec});
        if (cmp_dat) chk({t, ".o_data"}, odat[k], ed);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; dat[k] = '0; ctl[k] = '0; flush[k] = 1'b0; rdy[k] = 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 64'h0A, 8'h11, 1'b0, 1'b0, 1'b0, 64'h00, 8'h00, 2'd0, 1'b1};
        tbl[1]  = '{1'b1, 64'h0B, 8'h22, 1'b0, 1'b0, 1'b1, 64'h0A, 8'h11, 2'd1, 1'b1};
        tbl[2]  = '{1'b1, 64'h0C, 8'h33, 1'b0, 1'b0, 1'b1, 64'h0A, 8'h11, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 64'h0C, 8'h33, 1'b0, 1'b0, 1'b1, 64'h0A, 8'h11, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 64'h0C, 8'h33, 1'b0, 1'b1, 1'b1, 64'h0A, 8'h11, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 64'h0C, 8'h33, 1'b0, 1'b1, 1'b1, 64'h0B, 8'h22, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 64'h00, 8'h00, 1'b0, 1'b1, 1'b1, 64'h0C, 8'h33, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 64'h00, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0C, 8'h00, 2'd0, 1'b1};
        tbl[8]  = '{1'b1, 64'h44, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0C, 8'h00, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 64'h66, 8'h0E, 1'b0, 1'b0, 1'b1, 64'h44, 8'h0F, 2'd1, 1'b1};
        tbl[10] = '{1'b1, 64'h55, 8'hFF, 1'b1, 1'b0, 1'b1, 64'h44, 8'h0F, 2'd2, 1'b0};
        tbl[11] = '{1'b1, 64'h77, 8'h01, 1'b1, 1'b1, 1'b0, 64'h44, 8'h00, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 64'h00, 8'h00, 1'b0, 1'b1, 1'b0, 64'h44, 8'h00, 2'd0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_out(1, "reset_skid", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b1);
        check_out(0, "reset_noskid", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b1);

        // Back-pressure into FULL, drain in order, then flush from FULL with a live input.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            vld[1] = tbl[i].v; dat[1] = tbl[i].d; ctl[1] = tbl[i].c;
            flush[1] = tbl[i].f; rdy[1] = tbl[i].r;
            @(negedge clk);
            check_out(1, $sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec,
                      tbl[i].en, tbl[i].er, 1'b1);
        end

        // Streaming with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1 vld[1] = 1'b1; dat[1] = 64'(i); ctl[1] = 8'(i + 16); flush[1] = 1'b0; rdy[1] = 1'b1;
            @(negedge clk);
            if (i == 1) check_out(1, "stream_first", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b0);
            else check_out(1, $sformatf("stream%0d", i), 1'b1, 64'(i - 1), 8'(i + 15), 2'd1, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        check_out(1, "stream_last", 1'b1, 64'd8, 8'd24, 2'd1, 1'b1, 1'b1);

        // Single-entry stall: o_ready follows i_ready combinationally while holding data.
        @(posedge clk);
        #1 vld[0] = 1'b1; dat[0] = 64'h10; ctl[0] = 8'h01; rdy[0] = 1'b0;
        @(negedge clk);
        check_out(0, "s0_empty", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1 dat[0] = 64'h20; ctl[0] = 8'h02;
        @(negedge clk);
        check_out(0, "s0_stall", 1'b1, 64'h10, 8'h01, 2'd1, 1'b0, 1'b1);
        #1 rdy[0] = 1'b1;
        #1 chk("s0_ready_comb", {63'd0, ordy[0]}, 64'd1);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(negedge clk);
        check_out(0, "s0_reload", 1'b1, 64'h20, 8'h02, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        check_out(0, "s0_drained", 1'b0, 64'h20, 8'h00, 2'd0, 1'b1, 1'b1);

        // Asynchronous reset while the skid stage is FULL.
        @(posedge clk);
        #1 vld[1] = 1'b1; dat[1] = 64'h1; ctl[1] = 8'h3; rdy[1] = 1'b0;
        @(posedge clk);
        #1 dat[1] = 64'h2; ctl[1] = 8'h4;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        check_out(1, "pre_reset_full", 1'b1, 64'h1, 8'h3, 2'd2, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check_out(1, "async_reset", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0; vld[1] = 1'b1; dat[1] = 64'hA5; ctl[1] = 8'h5A; rdy[1] = 1'b1;
        @(negedge clk);
        check_out(1, "post_reset_wait", 1'b0, 64'h0, 8'h0, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        check_out(1, "post_reset_a5", 1'b1, 64'hA5, 8'h5A, 2'd1, 1'b1, 1'b1);

        // Random traffic on both instances against the in-order reference model.
        @(posedge clk);
        #1 rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        rp = 70;
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; rd[k] = 0; acc[k] = 1'b1;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 500 == 0) rp = $urandom_range(20, 95);
            for (int k = 0; k < 2; k++) begin
                if (!vld[k] || acc[k]) begin
                    vld[k] = ($urandom_range(0, 99) < 70);
                    dat[k] = {$urandom, $urandom};
                    ctl[k] = 8'($urandom);
                end
                rdy[k]   = ($urandom_range(0, 99) < rp);
                flush[k] = ($urandom_range(0, 49) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tag = (k == 1) ? "rnd_skid" : "rnd_noskid";
                n = wr[k] - rd[k];
                exp_rdy = (k == 1) ? (n < 2) : (n == 0 || rdy[k]);
                check_out(k, tag, (n > 0), mem[k][rd[k] % 16][63:0],
                          (n > 0) ? mem[k][rd[k] % 16][71:64] : 8'h0, 2'(n), exp_rdy, (n > 0));
                acc[k] = vld[k] && exp_rdy;
                if (flush[k]) begin
                    rd[k] = wr[k];
                end else begin
                    if (n > 0 && rdy[k]) rd[k] = rd[k] + 1;
                    if (acc[k]) begin
                        mem[k][wr[k] % 16] = {ctl[k], dat[k]};
                        wr[k] = wr[k] + 1;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register for the RISC-V core, intended to replace the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary data payload plus a control vector per stage, and adds valid/ready flow control, stall back-pressure, flush (bubble insertion) and an optional two-entry skid buffer for full throughput with a registered ready. One instance sits between each pair of adjacent pipeline stages.

## Interface
- DATA_WIDTH, 64: payload bits (operands, immediate, rd_sel, funct fields, packed by the instantiator)
- CTRL_WIDTH, 8: control bits (mem_write, mem_read, mem_to_reg, reg_wr_en, alu_src, ...); forced to zero on any bubble
- SKID, 1: 1 = two-entry skid buffer, registered o_ready; 0 = single entry, combinational o_ready
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  upstream holds a valid instruction
- o_ready  output  1  stage can accept this cycle
- i_data  input  DATA_WIDTH  upstream payload
- i_ctrl  input  CTRL_WIDTH  upstream control vector
- i_flush  input  1  kill all contents and the incoming transfer
- o_valid  output  1  stage output valid
- i_ready  input  1  downstream accepts this cycle
- o_data  output  DATA_WIDTH  payload to downstream
- o_ctrl  output  CTRL_WIDTH  control to downstream; all-zero whenever o_valid=0
- o_count  output  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Transfer in: i_valid && o_ready at a rising edge. Transfer out: o_valid && i_ready.
- o_data/o_ctrl held stable while o_valid && !i_ready (no change until accepted or flushed).
- o_ctrl = 0 whenever o_valid = 0; o_data undefined-but-stable (retains last value) when invalid.
- SKID=0: single register; o_ready = !o_valid || i_ready (combinational). Accepted input loads main register; out-transfer without in-transfer clears o_valid.
- SKID=1: main register (drives outputs) plus skid register; o_ready = !skid_valid, registered. States:
  - EMPTY (count 0): in -> BUSY.
  - BUSY (count 1): in && out -> BUSY (main loads input); in && !out -> FULL (input to skid); out && !in -> EMPTY.
  - FULL (count 2): o_ready=0; out -> BUSY (skid moves to main); else stay.
- Ordering strictly FIFO; skid entry is always younger than main.
- Flush: i_flush at an edge -> all entries invalid, count 0, o_ctrl 0, state EMPTY. An in-transfer in the same cycle is discarded. Flush has priority over every transfer. o_ready is not gated by i_flush.
- i_valid ignored when o_ready=0; upstream must hold i_data/i_ctrl until transfer.

## Timing
- Latency: 1 cycle from in-transfer to o_valid (empty stage). Throughput 1 per cycle in both SKID modes when downstream always ready.
- SKID=1: o_ready deasserts the cycle after the stage reaches FULL; reasserts the cycle after the first out-transfer from FULL.
- Reset (asynchronous, immediate): o_valid=0, o_data=0, o_ctrl=0, o_count=0, skid empty, state EMPTY; o_ready=1 in both modes (SKID=0 follows from o_valid=0). Reset mid-operation discards all entries; first transfer allowed on the first edge after rst deasserts.
- Flush applies on the edge it is sampled; o_valid=0 from that edge.

## Test plan
- Streaming, i_ready=1, SKID=1: data 1..8 on consecutive cycles -> o_data 1..8 one cycle later each, o_count stays 1, o_ready never drops.
- Back-pressure, SKID=1: send A,B,C; i_ready=0 from the cycle A is valid -> A held, B in skid, count 2, o_ready=0, C held upstream; release i_ready -> A,B,C out in order, no loss or duplication.
- SKID=0 stall: o_valid=1, i_ready=0 -> o_ready=0 combinationally; i_ready=1 same cycle with i_valid -> o_ready=1, new data loaded next edge.
- Flush in FULL with simultaneous i_valid (data 0x55, ctrl 0xFF) -> next cycle o_valid=0, o_ctrl=0, count 0; 0x55 never appears.
- Async reset asserted mid-clock while FULL -> outputs 0 immediately without clock edge; o_ready=1; after deassert, single transfer 0xA5 appears after 1 cycle.
- Random valid/ready/flush, both SKID values, 10k cycles -> scoreboard: output order matches accepted-and-not-flushed inputs; o_ctrl=0 whenever o_valid=0.
